// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
// Holds the FSM state enum, accumulator sizing and the saturating narrowing function.
package mvm_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_X,
      S_COMPUTE,
      S_FLUSH,
      S_OUTPUT
   } state_e;

   function automatic int acc_w(input int k, input int b);
      return 2 * b + $clog2(k);
   endfunction

   // Counter width that never collapses to zero bits when the range is 1.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v, input int ow);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/mvm_stream_array_if.sv
// Host-side load/compute/output bus of the matrix-vector multiplier.
// slave is the multiplier side, master is the host/consumer side.
interface mvm_stream_array_if #(parameter int B = 8) ();
   logic                  load_a;
   logic                  load_x;
   logic                  start;
   logic                  in_valid;
   logic signed [B-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [2*B-1:0] out_data;
   logic                  busy;
   logic                  done;

   modport slave (
      input  load_a, load_x, start, in_valid, in_data, out_ready,
      output out_valid, out_data, busy, done
   );

   modport master (
      output load_a, load_x, start, in_valid, in_data, out_ready,
      input  out_valid, out_data, busy, done
   );
endinterface

// File: rtl/mvm_lane.sv
// One MAC lane: owns the A rows r with r % P == lane, runs read -> product -> accumulate,
// and keeps its y rows. Output narrowing saturates when MVM_SAT_EN is defined, else wraps.
module mvm_lane
   import mvm_pkg::*;
#(
   parameter int K     = 12,
   parameter int B     = 8,
   parameter int ROWS  = 12,
   parameter int ACC_W = acc_w(K, B)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   a_we_i,
   input  logic [cw(ROWS*K)-1:0]  a_waddr_i,
   input  logic signed [B-1:0]    a_wdata_i,
   input  logic                   rd_en_i,
   input  logic [cw(ROWS*K)-1:0]  rd_addr_i,
   input  logic signed [B-1:0]    x_i,
   input  logic                   first_i,
   input  logic                   last_i,
   input  logic [cw(ROWS)-1:0]    pass_i,
   input  logic [cw(ROWS)-1:0]    y_raddr_i,
   output logic signed [2*B-1:0]  y_rdata_o
);

   localparam int OW = 2 * B;
   localparam int RW = cw(ROWS);

   logic signed [B-1:0]     a_mem [ROWS*K];
   logic signed [OW-1:0]    y_mem [ROWS];

   logic                    v1_q, v2_q;
   logic                    first1_q, last1_q, first2_q, last2_q;
   logic [RW-1:0]           pass1_q, pass2_q;
   logic signed [B-1:0]     a1_q, x1_q;
   logic signed [OW-1:0]    prod_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_base, prod_ext, acc_sum;
   logic signed [OW-1:0]    y_wr;

   always_comb begin
      acc_base = first2_q ? '0 : acc_q;
      prod_ext = ACC_W'(prod_q);
      acc_sum  = acc_base + prod_ext;
`ifdef MVM_SAT_EN
      y_wr     = OW'(sat_narrow(64'(acc_sum), OW));
`else
      y_wr     = acc_sum[OW-1:0];
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         v1_q <= rd_en_i;
         v2_q <= v1_q;
      end
   end

   // Datapath and storage are deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (a_we_i) a_mem[a_waddr_i] <= a_wdata_i;
      a1_q     <= a_mem[rd_addr_i];
      x1_q     <= x_i;
      first1_q <= first_i;
      last1_q  <= last_i;
      pass1_q  <= pass_i;
      prod_q   <= OW'(a1_q) * OW'(x1_q);
      first2_q <= first1_q;
      last2_q  <= last1_q;
      pass2_q  <= pass1_q;
      if (v2_q) acc_q <= acc_sum;
      if (v2_q && last2_q) y_mem[pass2_q] <= y_wr;
   end

   assign y_rdata_o = y_mem[y_raddr_i];

endmodule

// File: rtl/mvm_stream_array.sv
// Signed matrix-vector multiplier y = A*x with P parallel lanes and a valid/ready result stream.
// Build option MVM_SAT_EN selects saturating rather than wrapping output narrowing.
//
// state     | meaning
// IDLE      | waiting for load_a / load_x / start (that priority)
// LOAD_A    | writing M*K words of A row-major on in_valid
// LOAD_X    | writing K words of x on in_valid
// COMPUTE   | issuing (M/P)*K reads, one column per cycle for every lane
// FLUSH     | two cycles to drain the MAC pipeline into y storage
// OUTPUT    | streaming y[0..M-1] under out_ready backpressure
module mvm_stream_array
   import mvm_pkg::*;
#(
   parameter int K = 12,
   parameter int M = 12,
   parameter int P = 1,
   parameter int B = 8
) (
   input logic               clk,
   input logic               reset,
   mvm_stream_array_if.slave bus
);

   localparam int ROWS  = M / P;
   localparam int ACC_W = acc_w(K, B);
   localparam int OW    = 2 * B;
   localparam int CW    = cw(K);
   localparam int LW    = cw(P);
   localparam int RW    = cw(ROWS);
   localparam int AW    = cw(ROWS * K);

   state_e               state_q, state_d;
   logic [CW-1:0]        ld_col_q, ld_col_d;
   logic [LW-1:0]        ld_lane_q, ld_lane_d;
   logic [RW-1:0]        ld_row_q, ld_row_d;
   logic [CW-1:0]        cmp_col_q, cmp_col_d;
   logic [RW-1:0]        cmp_pass_q, cmp_pass_d;
   logic                 flush_q, flush_d;
   logic [LW-1:0]        out_lane_q, out_lane_d;
   logic [RW-1:0]        out_idx_q, out_idx_d;
   logic                 out_valid_q, out_valid_d;
   logic signed [OW-1:0] out_data_q, out_data_d;
   logic                 done_q, done_d;

   logic [P-1:0]         a_we;
   logic                 x_we;
   logic                 rd_en;
   logic                 out_last;
   logic [LW-1:0]        rd_lane;
   logic [RW-1:0]        rd_idx;
   logic [AW-1:0]        a_waddr, rd_addr;
   logic signed [B-1:0]  x_mem [K];
   logic signed [OW-1:0] y_rd [P];

   assign a_waddr = AW'(int'(ld_row_q) * K + int'(ld_col_q));
   assign rd_addr = AW'(int'(cmp_pass_q) * K + int'(cmp_col_q));

   // Row to present next: advances on a handshake so the output register reloads without a bubble.
   always_comb begin
      rd_lane  = out_lane_q;
      rd_idx   = out_idx_q;
      out_last = (out_lane_q == LW'(P - 1)) && (out_idx_q == RW'(ROWS - 1));
      if (state_q == S_OUTPUT && out_valid_q && bus.out_ready && !out_last) begin
         if (out_lane_q == LW'(P - 1)) begin
            rd_lane = '0;
            rd_idx  = out_idx_q + RW'(1);
         end else begin
            rd_lane = out_lane_q + LW'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ld_col_d    = ld_col_q;
      ld_lane_d   = ld_lane_q;
      ld_row_d    = ld_row_q;
      cmp_col_d   = cmp_col_q;
      cmp_pass_d  = cmp_pass_q;
      flush_d     = flush_q;
      out_lane_d  = out_lane_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      a_we        = '0;
      x_we        = 1'b0;
      rd_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            ld_col_d    = '0;
            ld_lane_d   = '0;
            ld_row_d    = '0;
            cmp_col_d   = '0;
            cmp_pass_d  = '0;
            flush_d     = 1'b0;
            out_lane_d  = '0;
            out_idx_d   = '0;
            out_valid_d = 1'b0;
            if (bus.load_a)      state_d = S_LOAD_A;
            else if (bus.load_x) state_d = S_LOAD_X;
            else if (bus.start)  state_d = S_COMPUTE;
         end
         S_LOAD_A: begin
            if (bus.in_valid) begin
               a_we[ld_lane_q] = 1'b1;
               if (ld_col_q == CW'(K - 1)) begin
                  ld_col_d = '0;
                  if (ld_lane_q == LW'(P - 1)) begin
                     ld_lane_d = '0;
                     if (ld_row_q == RW'(ROWS - 1)) state_d  = S_IDLE;
                     else                           ld_row_d = ld_row_q + RW'(1);
                  end else begin
                     ld_lane_d = ld_lane_q + LW'(1);
                  end
               end else begin
                  ld_col_d = ld_col_q + CW'(1);
               end
            end
         end
         S_LOAD_X: begin
            if (bus.in_valid) begin
               x_we = 1'b1;
               if (ld_col_q == CW'(K - 1)) state_d  = S_IDLE;
               else                        ld_col_d = ld_col_q + CW'(1);
            end
         end
         S_COMPUTE: begin
            rd_en = 1'b1;
            if (cmp_col_q == CW'(K - 1)) begin
               cmp_col_d = '0;
               if (cmp_pass_q == RW'(ROWS - 1)) state_d    = S_FLUSH;
               else                             cmp_pass_d = cmp_pass_q + RW'(1);
            end else begin
               cmp_col_d = cmp_col_q + CW'(1);
            end
         end
         S_FLUSH: begin
            flush_d = 1'b1;
            if (flush_q) state_d = S_OUTPUT;
         end
         S_OUTPUT: begin
            out_lane_d = rd_lane;
            out_idx_d  = rd_idx;
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = y_rd[rd_lane];
            end else if (bus.out_ready) begin
               if (out_last) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  out_data_d  = y_rd[rd_lane];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         ld_col_q    <= '0;
         ld_lane_q   <= '0;
         ld_row_q    <= '0;
         cmp_col_q   <= '0;
         cmp_pass_q  <= '0;
         flush_q     <= 1'b0;
         out_lane_q  <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_col_q    <= ld_col_d;
         ld_lane_q   <= ld_lane_d;
         ld_row_q    <= ld_row_d;
         cmp_col_q   <= cmp_col_d;
         cmp_pass_q  <= cmp_pass_d;
         flush_q     <= flush_d;
         out_lane_q  <= out_lane_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (x_we) x_mem[ld_col_q] <= bus.in_data;
   end

   for (genvar j = 0; j < P; j++) begin : g_lane
      mvm_lane #(
         .K     (K),
         .B     (B),
         .ROWS  (ROWS),
         .ACC_W (ACC_W)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .a_we_i    (a_we[j]),
         .a_waddr_i (a_waddr),
         .a_wdata_i (bus.in_data),
         .rd_en_i   (rd_en),
         .rd_addr_i (rd_addr),
         .x_i       (x_mem[cmp_col_q]),
         .first_i   (cmp_col_q == '0),
         .last_i    (cmp_col_q == CW'(K - 1)),
         .pass_i    (cmp_pass_q),
         .y_raddr_i (rd_idx),
         .y_rdata_o (y_rd[j])
      );
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = done_q;

endmodule

// File: tb/tb_mvm_stream_array.sv
// Scoreboard bench for mvm_stream_array (K=4, M=4, P=2, B=8): expected rows are pushed at start,
// a negedge monitor pops them on each handshake and also checks hold-under-backpressure and done.
module tb_mvm_stream_array;

   localparam int K  = 4;
   localparam int M  = 4;
   localparam int P  = 2;
   localparam int B  = 8;
   localparam int OW = 2 * B;
   localparam int C  = (M / P) * K;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mvm_stream_array_if #(.B(B)) bus ();

   mvm_stream_array #(.K(K), .M(M), .P(P), .B(B)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int                   A_m [M][K];
   int                   x_m [K];
   logic signed [OW-1:0] exp_q [$];
   int                   n_tests = 0;
   int                   n_fail  = 0;
   bit                   exp_done = 1'b0;
   bit                   prev_valid = 1'b0;
   bit                   prev_ready = 1'b0;
   logic signed [OW-1:0] prev_data = '0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [OW-1:0] narrow(input longint s);
`ifdef MVM_SAT_EN
      if (s > 32767)  return 16'sd32767;
      if (s < -32768) return -16'sd32768;
`endif
      return OW'(s);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         exp_done   = 1'b0;
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, prev_data);
         end
         if (exp_done || bus.done) check("done_pulse", bus.done, exp_done);
         exp_done = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL extra_row: got %0d with no row expected", bus.out_data);
            end else begin
               check("y_row", bus.out_data, exp_q.pop_front());
               if (exp_q.size() == 0) exp_done = 1'b1;
            end
         end
         prev_valid = bus.out_valid;
         prev_ready = bus.out_ready;
         prev_data  = bus.out_data;
      end
   end

   task automatic load_a_seq(input bit gaps, input bit junk);
      int n = 0;
      bit g = 1'b0;
      bus.load_a = 1'b1;
      bus.start  = junk;
      tick();
      bus.load_a = 1'b0;
      while (n < M * K) begin
         check("busy_load_a", bus.busy, 1);
         bus.start  = junk;
         bus.load_x = junk;
         if (gaps && g) begin
            bus.in_valid = 1'b0;
            bus.in_data  = B'($urandom);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = B'(A_m[n / K][n % K]);
            n++;
         end
         g = !g;
         tick();
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.load_x   = 1'b0;
      check("idle_after_load_a", bus.busy, 0);
   endtask

   task automatic load_x_seq(input bit gaps, input bit junk);
      int n = 0;
      bit g = 1'b0;
      bus.load_x = 1'b1;
      bus.start  = junk;
      tick();
      bus.load_x = 1'b0;
      while (n < K) begin
         check("busy_load_x", bus.busy, 1);
         bus.start  = junk;
         bus.load_a = junk;
         if (gaps && g) begin
            bus.in_valid = 1'b0;
            bus.in_data  = B'($urandom);
         end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = B'(x_m[n]);
            n++;
         end
         g = !g;
         tick();
      end
      bus.in_valid = 1'b0;
      bus.start    = 1'b0;
      bus.load_a   = 1'b0;
      check("idle_after_load_x", bus.busy, 0);
   endtask

   // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles after first valid
   task automatic run(input int mode);
      int cyc = 0;
      int k = 0;
      int hold = 0;
      for (int r = 0; r < M; r++) begin
         longint s = 0;
         for (int c = 0; c < K; c++) s += longint'(A_m[r][c]) * longint'(x_m[c]);
         exp_q.push_back(narrow(s));
      end
      bus.out_ready = (mode == 0);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      while (!bus.out_valid && cyc < 100) begin
         if (mode == 1) bus.out_ready = 1'($urandom);
         tick();
         cyc++;
      end
      check("first_valid_latency", cyc, C + 3);
      while (!bus.done && k < 200) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom);
            default: begin
               bus.out_ready = (hold >= 5);
               hold++;
            end
         endcase
         tick();
         k++;
      end
      check("done_seen", bus.done, 1);
      check("rows_left", exp_q.size(), 0);
      bus.out_ready = 1'b0;
   endtask

   task automatic rand_a();
      for (int r = 0; r < M; r++)
         for (int c = 0; c < K; c++) A_m[r][c] = int'($urandom_range(255)) - 128;
   endtask

   task automatic rand_x();
      for (int c = 0; c < K; c++) x_m[c] = int'($urandom_range(255)) - 128;
   endtask

   initial begin
      bus.load_a    = 1'b0;
      bus.load_x    = 1'b0;
      bus.start     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      check("rst_busy", bus.busy, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_done", bus.done, 0);
      reset = 1'b0;
      tick();

      for (int r = 0; r < M; r++)
         for (int c = 0; c < K; c++) A_m[r][c] = (r == c) ? 1 : 0;
      for (int c = 0; c < K; c++) x_m[c] = c + 1;
      load_a_seq(1'b0, 1'b0);
      load_x_seq(1'b0, 1'b0);
      run(0);

      rand_a();
      rand_x();
      load_a_seq(1'b1, 1'b0);
      load_x_seq(1'b1, 1'b0);
      run(2);

      for (int r = 0; r < M; r++)
         for (int c = 0; c < K; c++) A_m[r][c] = 127;
      for (int c = 0; c < K; c++) x_m[c] = 127;
      load_a_seq(1'b0, 1'b0);
      load_x_seq(1'b0, 1'b0);
      run(1);

      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("abort_busy", bus.busy, 0);
      check("abort_out_valid", bus.out_valid, 0);
      reset = 1'b0;
      tick();
      run(0);

      rand_a();
      load_a_seq(1'b0, 1'b1);
      tick();
      tick();
      check("start_ignored_busy", bus.busy, 0);
      check("start_ignored_valid", bus.out_valid, 0);
      x_m[0] = -1;
      for (int c = 1; c < K; c++) x_m[c] = 0;
      load_x_seq(1'b0, 1'b1);
      run(1);

      repeat (3) begin
         rand_a();
         rand_x();
         load_a_seq(1'($urandom), 1'b0);
         load_x_seq(1'($urandom), 1'b0);
         run(int'($urandom_range(2)));
      end

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
